led_pattern_gen: RTL and testbench

Multi-channel LED pattern generator that replaces the single fixed-rate blinker. A shared prescaler derives a slow tick from the system clock. Each of NUM_CH channels is independently configured at run time: off, on, continuous blink with programmable period and duty, or a counted burst that reports completion. It sits between the control/status logic and the board LED pins.

---
 rtl/led_pattern_gen.sv | 128 ++++++++++++
 tb/tb_led_pattern_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/led_pattern_gen.sv
// Multi-channel LED pattern generator: a shared prescaler tick drives per-channel
// OFF/ON/BLINK/BURST patterns with registered led/busy/done outputs.
module led_pattern_gen #(
  parameter int unsigned NUM_CH  = 4,
  parameter int unsigned FREQ_HZ = 100000000,
  parameter int unsigned TICK_HZ = 1000,
  parameter int unsigned CW      = 16,
  localparam int unsigned CHW    = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cfg_we,
  input  logic [CHW-1:0]    cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [CW-1:0]     cfg_period,
  input  logic [CW-1:0]     cfg_duty,
  input  logic [3:0]        cfg_count,
  output logic [NUM_CH-1:0] led,
  output logic [NUM_CH-1:0] busy,
  output logic [NUM_CH-1:0] done
);

  localparam int unsigned PRESC = FREQ_HZ / TICK_HZ;
  localparam int unsigned PW    = $clog2(PRESC);
  localparam logic [PW-1:0] PrescMax = PW'(PRESC - 1);

  typedef enum logic [1:0] {
    ModeOff   = 2'd0,
    ModeOn    = 2'd1,
    ModeBlink = 2'd2,
    ModeBurst = 2'd3
  } mode_e;

  logic [PW-1:0]     presc_q, presc_d;
  logic              tick;
  mode_e             mode_q   [NUM_CH];
  mode_e             mode_d   [NUM_CH];
  logic [CW-1:0]     period_q [NUM_CH];
  logic [CW-1:0]     period_d [NUM_CH];
  logic [CW-1:0]     duty_q   [NUM_CH];
  logic [CW-1:0]     duty_d   [NUM_CH];
  logic [CW-1:0]     ph_q     [NUM_CH];
  logic [CW-1:0]     ph_d     [NUM_CH];
  logic [3:0]        rem_q    [NUM_CH];
  logic [3:0]        rem_d    [NUM_CH];
  logic [NUM_CH-1:0] led_q, led_d, busy_q, busy_d, done_q, done_d;

  assign tick = (presc_q == PrescMax);

  always_comb begin : p_next
    logic [CW-1:0] pe;
    logic          wr;
    pe      = '0;
    wr      = 1'b0;
    presc_d = tick ? '0 : presc_q + 1'b1;
    led_d   = '0;
    busy_d  = '0;
    done_d  = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      mode_d[i]   = mode_q[i];
      period_d[i] = period_q[i];
      duty_d[i]   = duty_q[i];
      ph_d[i]     = ph_q[i];
      rem_d[i]    = rem_q[i];
      pe          = (period_q[i] == '0) ? CW'(1) : period_q[i];
      wr          = cfg_we && (32'(cfg_ch) == i);
      // A write wins over a coincident tick and aborts any burst silently.
      if (wr) begin
        mode_d[i]   = mode_e'(cfg_mode);
        period_d[i] = cfg_period;
        duty_d[i]   = cfg_duty;
        ph_d[i]     = '0;
        rem_d[i]    = cfg_count;
        done_d[i]   = (mode_e'(cfg_mode) == ModeBurst) && (cfg_count == 4'd0);
      end else if (tick && ((mode_q[i] == ModeBlink) ||
                            ((mode_q[i] == ModeBurst) && (rem_q[i] != 4'd0)))) begin
        if (ph_q[i] >= pe - 1'b1) begin
          ph_d[i] = '0;
          if (mode_q[i] == ModeBurst) begin
            rem_d[i]  = rem_q[i] - 1'b1;
            done_d[i] = (rem_q[i] == 4'd1);
          end
        end else begin
          ph_d[i] = ph_q[i] + 1'b1;
        end
      end
      unique case (mode_d[i])
        ModeOff:   led_d[i] = 1'b0;
        ModeOn:    led_d[i] = 1'b1;
        ModeBlink: led_d[i] = (ph_d[i] < duty_d[i]);
        ModeBurst: led_d[i] = (rem_d[i] != 4'd0) && (ph_d[i] < duty_d[i]);
        default:   led_d[i] = 1'b0;
      endcase
      busy_d[i] = (mode_d[i] == ModeBurst) && (rem_d[i] != 4'd0);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q <= '0;
      led_q   <= '0;
      busy_q  <= '0;
      done_q  <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        mode_q[i]   <= ModeOff;
        period_q[i] <= '0;
        duty_q[i]   <= '0;
        ph_q[i]     <= '0;
        rem_q[i]    <= '0;
      end
    end else begin
      presc_q  <= presc_d;
      led_q    <= led_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mode_q   <= mode_d;
      period_q <= period_d;
      duty_q   <= duty_d;
      ph_q     <= ph_d;
      rem_q    <= rem_d;
    end
  end

  assign led  = led_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_led_pattern_gen.sv
// Randomized bench for led_pattern_gen; the model tracks ticks elapsed since each
// channel's last write and derives led/busy/done arithmetically from that count.
module tb_led_pattern_gen;
  localparam int NCH   = 4;
  localparam int PRESC = 10;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_we = 1'b0;
  logic [2:0]  cfg_ch = '0;
  logic [1:0]  cfg_mode = '0;
  logic [15:0] cfg_period = '0;
  logic [15:0] cfg_duty = '0;
  logic [3:0]  cfg_count = '0;
  logic        we4;
  logic [3:0]  led4, busy4, done4;
  logic [4:0]  led5, busy5, done5;

  // The 4-channel instance cannot encode channel 5, so its strobe is gated instead.
  assign we4 = cfg_we && (cfg_ch < 3'd4);

  led_pattern_gen #(.NUM_CH(4), .FREQ_HZ(100), .TICK_HZ(10), .CW(16)) u_dut4 (
    .clk(clk), .reset(reset), .cfg_we(we4), .cfg_ch(cfg_ch[1:0]), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_count(cfg_count),
    .led(led4), .busy(busy4), .done(done4)
  );

  led_pattern_gen #(.NUM_CH(5), .FREQ_HZ(100), .TICK_HZ(10), .CW(16)) u_dut5 (
    .clk(clk), .reset(reset), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_period(cfg_period), .cfg_duty(cfg_duty), .cfg_count(cfg_count),
    .led(led5), .busy(busy5), .done(done5)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  int m_mode [NCH];
  int m_per  [NCH];
  int m_duty [NCH];
  int m_cnt  [NCH];
  int m_nt   [NCH];
  bit m_chg  [NCH];
  int cyc = 0;

  task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic step();
    logic [3:0] el, eb, ed;
    int p, ph;
    bit active;
    @(posedge clk);
    if (reset) begin
      cyc = 0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] = 0; m_per[c] = 0; m_duty[c] = 0; m_cnt[c] = 0; m_nt[c] = 0; m_chg[c] = 0;
      end
    end else begin
      cyc++;
      for (int c = 0; c < NCH; c++) begin
        m_chg[c] = 0;
        if (cfg_we && (int'(cfg_ch) == c)) begin
          m_mode[c] = int'(cfg_mode); m_per[c] = int'(cfg_period);
          m_duty[c] = int'(cfg_duty); m_cnt[c] = int'(cfg_count);
          m_nt[c] = 0; m_chg[c] = 1;
        end else if (cyc % PRESC == 0) begin
          m_nt[c]++; m_chg[c] = 1;
        end
      end
    end
    #1;
    el = '0; eb = '0; ed = '0;
    for (int c = 0; c < NCH; c++) begin
      p  = (m_per[c] == 0) ? 1 : m_per[c];
      ph = m_nt[c] % p;
      case (m_mode[c])
        1: el[c] = 1'b1;
        2: el[c] = (ph < m_duty[c]);
        3: begin
          active = (m_nt[c] / p) < m_cnt[c];
          el[c]  = active && (ph < m_duty[c]);
          eb[c]  = active;
          ed[c]  = m_chg[c] && (m_nt[c] == m_cnt[c] * p);
        end
        default: el[c] = 1'b0;
      endcase
    end
    check_eq("led", 32'(led4), 32'(el));
    check_eq("busy", 32'(busy4), 32'(eb));
    check_eq("done", 32'(done4), 32'(ed));
    check_eq("led_n5", 32'(led5), 32'({1'b0, el}));
    check_eq("busy_n5", 32'(busy5), 32'({1'b0, eb}));
    check_eq("done_n5", 32'(done5), 32'({1'b0, ed}));
  endtask

  task automatic wr(input int ch, input int mode, input int per, input int duty, input int cnt);
    cfg_we = 1'b1; cfg_ch = 3'(ch); cfg_mode = 2'(mode);
    cfg_period = 16'(per); cfg_duty = 16'(duty); cfg_count = 4'(cnt);
    step();
    cfg_we = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step();
  endtask

  // Leaves the bench so that the next edge is a tick edge.
  task automatic align_tick();
    while ((cyc + 1) % PRESC != 0) step();
  endtask

  initial begin
    int hi, dn, bz, r, n;
    int chs [7] = '{0, 1, 2, 3, 5, 6, 7};

    reset = 1'b1;
    idle(3);
    check_eq("reset_led", 32'(led4), 32'h0);
    reset = 1'b0;

    // BLINK ch1 period 4 duty 1 written on the first edge after reset release.
    wr(1, 2, 4, 1, 0);
    idle(100);
    hi = 0;
    repeat (40) begin step(); hi += int'(led4[1]); end
    check_eq("blink_hi_per_40", 32'(hi), 32'd10);

    // BURST ch0 period 2 duty 1 count 3, written on a tick edge for full-width pulses.
    align_tick();
    wr(0, 3, 2, 1, 3);
    hi = int'(led4[0]); dn = 0; bz = int'(busy4[0]);
    repeat (69) begin
      step();
      hi += int'(led4[0]); dn += int'(done4[0]); bz += int'(busy4[0]);
    end
    check_eq("burst_hi", 32'(hi), 32'd30);
    check_eq("burst_done_cnt", 32'(dn), 32'd1);
    check_eq("burst_busy_cycles", 32'(bz), 32'd60);
    check_eq("burst_led_after", 32'(led4[0]), 32'd0);

    // Edge configurations on ch2.
    wr(2, 2, 3, 5, 0); idle(50);
    check_eq("duty_gt_period", 32'(led4[2]), 32'd1);
    wr(2, 2, 4, 0, 0); idle(50);
    check_eq("duty_zero", 32'(led4[2]), 32'd0);
    wr(2, 2, 0, 1, 0); idle(30);
    check_eq("period_zero", 32'(led4[2]), 32'd1);
    wr(2, 3, 4, 2, 0);
    check_eq("burst0_done", 32'(done4[2]), 32'd1);
    idle(20);

    // Rewrite mid-burst, then an out-of-range channel write.
    wr(0, 3, 3, 2, 5); idle(25);
    wr(0, 1, 0, 0, 0);
    check_eq("rewrite_led", 32'(led4[0]), 32'd1);
    check_eq("rewrite_busy", 32'(busy4[0]), 32'd0);
    wr(5, 1, 1, 1, 1); idle(20);

    // Reset mid-burst, then a write coincident with a tick.
    wr(0, 3, 2, 1, 4); idle(15);
    reset = 1'b1; step(); reset = 1'b0;
    check_eq("reset_mid_burst", 32'({led4, busy4, done4}), 32'h0);
    idle(20);
    align_tick();
    wr(3, 2, 3, 1, 0);
    idle(40);

    repeat (400) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        reset = 1'b1;
        idle($urandom_range(1, 2));
        reset = 1'b0;
      end else if (r < 8) begin
        if ($urandom_range(0, 3) == 0) align_tick();
        wr(chs[$urandom_range(0, 6)], $urandom_range(0, 3), $urandom_range(0, 5),
           $urandom_range(0, 6), $urandom_range(0, 5));
      end else begin
        n = $urandom_range(1, 15);
        idle(n);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
